// File: rtl/post_proc_pkg.sv
// Shared types for the post-processing stage: mode encoding, configuration
// record and the reset threshold helper.
// Ports: none (package).
package post_proc_pkg;

    // Field widths of the configuration record; they match the default
    // SHIFT_W / DATA_W of post_proc_pipe, and other builds cast to/from them.
    localparam int PP_SHIFT_W  = 4;
    localparam int PP_THRESH_W = 8;

    typedef enum logic [1:0] {
        PP_PASS   = 2'd0,
        PP_SHIFT  = 2'd1,
        PP_OFFSET = 2'd2,
        PP_THRESH = 2'd3
    } pp_mode_e;

    typedef struct packed {
        pp_mode_e                mode;
        logic [PP_SHIFT_W-1:0]   shift;
        logic [PP_THRESH_W-1:0]  thresh;
    } pp_cfg_t;

    // Quarter-scale threshold used after reset.
    function automatic logic [PP_THRESH_W-1:0] pp_default_thresh(input int data_w);
        return PP_THRESH_W'(1) << (data_w - 2);
    endfunction

endpackage

// File: rtl/pp_channel.sv
// One colour channel of the post-processing datapath: S1 (shift/offset),
// S2 (clamp, threshold, saturation flag). Both stages advance on en.
// Ports: clk/reset/en, per-stage mode, shift, thresh, raw sample in,
// value (clamped pixel) and sat (sample left the output range) out.
module pp_channel
    import post_proc_pkg::*;
#(
    parameter int IN_W    = 12,
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  pp_mode_e          s1_mode,
    input  logic [SHIFT_W-1:0] shift,
    input  pp_mode_e          s2_mode,
    input  logic [DATA_W-1:0] thresh,
    input  logic [IN_W-1:0]   raw,
    output logic [DATA_W-1:0] value,
    output logic              sat
);

    // One extra bit so the mid-scale offset can never overflow.
    localparam int V_W = IN_W + 1;
    localparam logic signed [V_W-1:0] MID = V_W'(2 ** (DATA_W - 1));
    localparam logic [DATA_W-1:0]     MAX = '1;

    logic signed [V_W-1:0] ext;
    logic signed [V_W-1:0] v_next;
    logic signed [V_W-1:0] v_q;
    logic                  neg;
    logic                  over;
    logic [DATA_W-1:0]     clamp;
    logic [DATA_W-1:0]     res_next;

    assign ext = {raw[IN_W-1], raw};

    // Arithmetic shift: large shift amounts collapse to 0 or -1, and -1
    // clamps to 0 in S2.
    always_comb begin
        v_next = ext;
        case (s1_mode)
            PP_SHIFT:  v_next = ext >>> shift;
            PP_OFFSET: v_next = ext + MID;
            default:   v_next = ext;
        endcase
    end

    // v_q is known non-negative when 'over' is evaluated, so any set bit
    // above the output width means it exceeds MAX.
    always_comb begin
        neg      = v_q[V_W-1];
        over     = !neg && (v_q[V_W-2:DATA_W] != '0);
        clamp    = neg ? '0 : (over ? MAX : v_q[DATA_W-1:0]);
        res_next = clamp;
        if (s2_mode == PP_THRESH) begin
            res_next = (clamp >= thresh) ? MAX : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            value <= '0;
            sat   <= 1'b0;
        end else if (en) begin
            v_q   <= v_next;
            value <= res_next;
            sat   <= neg || over;
        end
    end

endmodule

// File: rtl/post_proc_pipe.sv
// Post-processing stage: signed wide convolution results -> saturated
// unsigned pixels, 2-cycle latency, 1 pixel/cycle, stalls on i_ready.
// Ports: valid/ready pixel in (i_data, i_last) and out (o_data, o_last),
// shadowed config load (i_cfg_load/i_mode/i_shift/i_thresh, o_cfg_busy),
// per-frame saturation count (o_sat_count, o_sat_valid).
module post_proc_pipe
    import post_proc_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 12,
    parameter int DATA_W   = 8,
    parameter int SHIFT_W  = 4,
    parameter int CNT_W    = 24
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [CHANNELS-1:0][IN_W-1:0]    i_data,
    input  logic                             i_last,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [CHANNELS-1:0][DATA_W-1:0]  o_data,
    output logic                             o_last,
    input  logic                             i_cfg_load,
    input  logic [1:0]                       i_mode,
    input  logic [SHIFT_W-1:0]               i_shift,
    input  logic [DATA_W-1:0]                i_thresh,
    output logic                             o_cfg_busy,
    output logic [CNT_W-1:0]                 o_sat_count,
    output logic                             o_sat_valid
);

    localparam pp_cfg_t CFG_RST = '{mode: PP_PASS, shift: '0,
                                    thresh: pp_default_thresh(DATA_W)};

    pp_cfg_t             active_cfg;
    pp_cfg_t             pend_cfg;
    logic                cfg_pending;
    logic                s1_valid;
    logic                s1_last;
    logic                s2_valid;
    logic                s2_last;
    logic                en;
    logic                accept;
    logic                apply;
    logic                xfer;
    logic [CHANNELS-1:0] sat_ch;
    logic                pixel_sat;
    logic [CNT_W-1:0]    sat_cnt;
    logic [CNT_W-1:0]    cnt_inc;

    assign en         = !s2_valid || i_ready;
    assign o_ready    = en && !cfg_pending;
    assign accept     = i_valid && o_ready;
    // Config swaps only once both stages are empty, so every in-flight
    // pixel finishes with the configuration it entered under.
    assign apply      = cfg_pending && !s1_valid && !s2_valid;
    assign xfer       = s2_valid && i_ready;
    assign pixel_sat  = |sat_ch;
    assign o_valid    = s2_valid;
    assign o_last     = s2_last;
    assign o_cfg_busy = cfg_pending;

    // Saturating increment: sticks at all-ones instead of wrapping.
    assign cnt_inc = (xfer && pixel_sat && (sat_cnt != '1)) ? sat_cnt + CNT_W'(1) : sat_cnt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pp_channel #(
            .IN_W   (IN_W),
            .DATA_W (DATA_W),
            .SHIFT_W(SHIFT_W)
        ) u_ch (
            .clk    (i_clk),
            .reset  (i_reset),
            .en     (en),
            .s1_mode(active_cfg.mode),
            .shift  (SHIFT_W'(active_cfg.shift)),
            .s2_mode(active_cfg.mode),
            .thresh (DATA_W'(active_cfg.thresh)),
            .raw    (i_data[g]),
            .value  (o_data[g]),
            .sat    (sat_ch[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            active_cfg  <= CFG_RST;
            pend_cfg    <= CFG_RST;
            cfg_pending <= 1'b0;
            sat_cnt     <= '0;
            o_sat_count <= '0;
            o_sat_valid <= 1'b0;
        end else begin
            if (en) begin
                s1_valid <= accept;
                s1_last  <= accept && i_last;
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
            end

            // A load arriving in the apply cycle wins: it stays pending and
            // is applied on the following cycle.
            if (i_cfg_load) begin
                pend_cfg    <= '{mode: pp_mode_e'(i_mode),
                                 shift: PP_SHIFT_W'(i_shift),
                                 thresh: PP_THRESH_W'(i_thresh)};
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
            if (apply) begin
                active_cfg <= pend_cfg;
            end

            o_sat_valid <= 1'b0;
            if (xfer && s2_last) begin
                o_sat_count <= cnt_inc;
                o_sat_valid <= 1'b1;
                sat_cnt     <= '0;
            end else begin
                sat_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_post_proc_pipe.sv
// Directed bench for post_proc_pipe: single-pixel vector table per mode,
// then backpressure, mid-stream config load, frame statistics and reset.
module tb_post_proc_pipe;

    typedef logic [2:0][11:0] din_t;
    typedef logic [2:0][7:0]  dout_t;
    typedef struct packed { din_t d;  logic last; } tx_t;
    typedef struct packed { dout_t d; logic last; } rx_t;
    typedef struct {
        logic [1:0] mode;
        logic [3:0] shift;
        logic [7:0] thr;
        din_t       d;
        dout_t      e;
        logic       sat;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    din_t        i_data = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    dout_t       o_data;
    logic        o_last;
    logic        i_cfg_load = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [3:0]  i_shift = 4'd0;
    logic [7:0]  i_thresh = 8'd64;
    logic        o_cfg_busy;
    logic [23:0] o_sat_count;
    logic        o_sat_valid;

    int n_checks = 0;
    int n_fail = 0;
    int sat_pulses = 0;
    logic [23:0] sat_log[$];
    tx_t tx_q[$];
    rx_t exp_q[$];
    vec_t vecs[10];

    always #5 i_clk = ~i_clk;

    post_proc_pipe dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .i_cfg_load(i_cfg_load), .i_mode(i_mode),
        .i_shift(i_shift), .i_thresh(i_thresh), .o_cfg_busy(o_cfg_busy),
        .o_sat_count(o_sat_count), .o_sat_valid(o_sat_valid)
    );

    always @(negedge i_clk) begin
        if (o_sat_valid) begin
            sat_pulses++;
            sat_log.push_back(o_sat_count);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic din_t mk_in(input int a, input int b, input int c);
        din_t r;
        r[0] = a[11:0];
        r[1] = b[11:0];
        r[2] = c[11:0];
        return r;
    endfunction

    function automatic dout_t mk_out(input int a, input int b, input int c);
        dout_t r;
        r[0] = a[7:0];
        r[1] = b[7:0];
        r[2] = c[7:0];
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] m, input logic [3:0] s, input logic [7:0] t,
                                    input din_t d, input dout_t e, input logic sat);
        vec_t v;
        v.mode = m; v.shift = s; v.thr = t; v.d = d; v.e = e; v.sat = sat;
        return v;
    endfunction

    // Issue a config load with the pipe idle; busy must show then clear.
    task automatic load_cfg(input logic [1:0] m, input logic [3:0] s, input logic [7:0] t);
        @(negedge i_clk);
        i_cfg_load = 1'b1; i_mode = m; i_shift = s; i_thresh = t;
        @(negedge i_clk);
        i_cfg_load = 1'b0;
        #1;
        check("cfg_busy_set", o_cfg_busy, 1);
        for (int k = 0; k < 10; k++) begin
            if (!o_cfg_busy) break;
            @(negedge i_clk);
            #1;
        end
        check("cfg_busy_clear", o_cfg_busy, 0);
    endtask

    // Drive tx_q, compare outputs against exp_q. bp != 0 applies a stall
    // pattern 1,0,0,0,1,1 on i_ready.
    task automatic run_stream(input int bp, input int max_cyc);
        logic  held_vld;
        dout_t held_d;
        logic  held_l;
        int    cyc;
        held_vld = 1'b0; held_d = '0; held_l = 1'b0; cyc = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
            i_ready = (bp != 0 && (cyc % 6) inside {1, 2, 3}) ? 1'b0 : 1'b1;
            if (tx_q.size() > 0) begin
                i_valid = 1'b1; i_data = tx_q[0].d; i_last = tx_q[0].last;
            end else begin
                i_valid = 1'b0; i_last = 1'b0;
            end
            #1;
            if (held_vld) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, held_d);
                check("hold_last", o_last, held_l);
            end
            check("ready_rule", o_ready, !(o_valid && !i_ready) && !o_cfg_busy);
            if (i_valid && o_ready) void'(tx_q.pop_front());
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    check("stream_data", o_data, exp_q[0].d);
                    check("stream_last", o_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                held_vld = 1'b0;
            end else begin
                held_vld = o_valid;
                held_d = o_data;
                held_l = o_last;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        check("stream_done", exp_q.size(), 0);
        tx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int p0;
        vecs[0] = mk_vec(2'd0, 4'd0,  8'd64,  mk_in(300, -5, 100),     mk_out(255, 0, 100), 1'b1);
        vecs[1] = mk_vec(2'd1, 4'd4,  8'd64,  mk_in(2047, -16, 160),   mk_out(127, 0, 10),  1'b1);
        vecs[2] = mk_vec(2'd2, 4'd0,  8'd64,  mk_in(-128, 0, 200),     mk_out(0, 128, 255), 1'b1);
        vecs[3] = mk_vec(2'd3, 4'd0,  8'd64,  mk_in(63, 64, -1),       mk_out(0, 255, 0),   1'b1);
        vecs[4] = mk_vec(2'd0, 4'd0,  8'd64,  mk_in(0, 255, 17),       mk_out(0, 255, 17),  1'b0);
        vecs[5] = mk_vec(2'd1, 4'd12, 8'd64,  mk_in(2047, 0, 1),       mk_out(0, 0, 0),     1'b0);
        vecs[6] = mk_vec(2'd1, 4'd15, 8'd64,  mk_in(-2048, 2047, -1),  mk_out(0, 0, 0),     1'b1);
        vecs[7] = mk_vec(2'd2, 4'd0,  8'd64,  mk_in(127, -128, 0),     mk_out(255, 0, 128), 1'b0);
        vecs[8] = mk_vec(2'd3, 4'd0,  8'd64,  mk_in(100, 0, 255),      mk_out(255, 0, 255), 1'b0);
        vecs[9] = mk_vec(2'd3, 4'd0,  8'd200, mk_in(199, 200, 256),    mk_out(0, 255, 255), 1'b1);

        // Reset state
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_last", o_last, 0);
        check("rst_sat_count", o_sat_count, 0);
        check("rst_sat_valid", o_sat_valid, 0);
        check("rst_cfg_busy", o_cfg_busy, 0);
        check("rst_o_ready", o_ready, 1);

        // Single-pixel frames, one per vector, checking latency and stats
        for (int v = 0; v < 10; v++) begin
            load_cfg(vecs[v].mode, vecs[v].shift, vecs[v].thr);
            i_ready = 1'b1; i_valid = 1'b1; i_data = vecs[v].d; i_last = 1'b1;
            #1;
            check("vec_ready", o_ready, 1);
            @(negedge i_clk);
            i_valid = 1'b0; i_last = 1'b0;
            #1;
            check("vec_lat_n1", o_valid, 0);
            @(negedge i_clk);
            #1;
            check("vec_valid_n2", o_valid, 1);
            check("vec_data", o_data, vecs[v].e);
            check("vec_last", o_last, 1);
            @(negedge i_clk);
            #1;
            check("vec_sat_pulse", o_sat_valid, 1);
            check("vec_sat_count", o_sat_count, {23'd0, vecs[v].sat});
            check("vec_drained", o_valid, 0);
            @(negedge i_clk);
            #1;
            check("vec_pulse_once", o_sat_valid, 0);
        end

        // Backpressure: 6 pixels, PASS
        load_cfg(2'd0, 4'd0, 8'd64);
        for (int k = 0; k < 6; k++) begin
            tx_q.push_back('{d: mk_in(k*10+1, k*10+2, k*10+3), last: (k == 5)});
            exp_q.push_back('{d: mk_out(k*10+1, k*10+2, k*10+3), last: (k == 5)});
        end
        run_stream(1, 60);

        // Mid-stream config load with two pixels in flight
        load_cfg(2'd0, 4'd0, 8'd64);
        sat_log.delete();
        i_ready = 1'b1; i_valid = 1'b1; i_data = mk_in(300, -5, 100); i_last = 1'b0;
        @(negedge i_clk);
        i_data = mk_in(7, 8, 9);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_cfg_load = 1'b1; i_mode = 2'd1; i_shift = 4'd2; i_thresh = 8'd64;
        #1;
        check("mid_p1_valid", o_valid, 1);
        check("mid_p1_pass", o_data, mk_out(255, 0, 100));
        @(negedge i_clk);
        i_cfg_load = 1'b0;
        #1;
        check("mid_busy", o_cfg_busy, 1);
        check("mid_ready_low", o_ready, 0);
        check("mid_p2_pass", o_data, mk_out(7, 8, 9));
        @(negedge i_clk);
        #1;
        check("mid_drained", o_valid, 0);
        check("mid_busy_drain", o_cfg_busy, 1);
        tx_q.push_back('{d: mk_in(40, -8, 1023), last: 1'b1});
        exp_q.push_back('{d: mk_out(10, 0, 255), last: 1'b1});
        run_stream(0, 20);
        repeat (2) @(negedge i_clk);
        check("mid_pulses", sat_log.size(), 1);
        check("mid_sat_count", (sat_log.size() > 0) ? sat_log[0] : 24'hFFFFFF, 2);

        // Frame statistics: 10 pixels (3 saturating) then 2 clean
        load_cfg(2'd0, 4'd0, 8'd64);
        sat_log.delete();
        p0 = sat_pulses;
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 5 || k == 9) begin
                tx_q.push_back('{d: mk_in(300, 0, 0), last: (k == 9)});
                exp_q.push_back('{d: mk_out(255, 0, 0), last: (k == 9)});
            end else begin
                tx_q.push_back('{d: mk_in(k, k+1, k+2), last: 1'b0});
                exp_q.push_back('{d: mk_out(k, k+1, k+2), last: 1'b0});
            end
        end
        run_stream(0, 40);
        tx_q.push_back('{d: mk_in(20, 21, 22), last: 1'b0});
        exp_q.push_back('{d: mk_out(20, 21, 22), last: 1'b0});
        tx_q.push_back('{d: mk_in(23, 24, 25), last: 1'b1});
        exp_q.push_back('{d: mk_out(23, 24, 25), last: 1'b1});
        run_stream(0, 20);
        repeat (3) @(negedge i_clk);
        check("frame_pulses", sat_pulses - p0, 2);
        check("frame1_count", (sat_log.size() > 0) ? sat_log[0] : 24'hFFFFFF, 3);
        check("frame2_count", (sat_log.size() > 1) ? sat_log[1] : 24'hFFFFFF, 0);

        // Reset mid-frame with SHIFT active: drop pixels, drop count, back to PASS
        load_cfg(2'd1, 4'd4, 8'd64);
        sat_log.delete();
        p0 = sat_pulses;
        i_ready = 1'b1; i_valid = 1'b1; i_data = mk_in(-300, 0, 0); i_last = 1'b0;
        repeat (3) @(negedge i_clk);
        i_valid = 1'b0; i_ready = 1'b0; i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0; i_ready = 1'b1;
        #1;
        check("mrst_o_valid", o_valid, 0);
        check("mrst_sat_valid", o_sat_valid, 0);
        check("mrst_cfg_busy", o_cfg_busy, 0);
        check("mrst_o_ready", o_ready, 1);
        tx_q.push_back('{d: mk_in(300, 0, 0), last: 1'b0});
        exp_q.push_back('{d: mk_out(255, 0, 0), last: 1'b0});
        tx_q.push_back('{d: mk_in(160, 160, 160), last: 1'b1});
        exp_q.push_back('{d: mk_out(160, 160, 160), last: 1'b1});
        run_stream(0, 20);
        repeat (2) @(negedge i_clk);
        check("mrst_pulses", sat_pulses - p0, 1);
        check("mrst_count", (sat_log.size() > 0) ? sat_log[0] : 24'hFFFFFF, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
